// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-entry valid/ready output buffer.
// Mid-bit sampling from a 2-flop synchronized line; a held-low line parks in BREAK.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 310,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       uart_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state_q, state_d;
  logic             rx_meta, rx_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       sh_q, sh_d;
  logic             stop_ok, stop_bad;
  logic             pend_q;

  // Two-flop synchronizer; idles high so reset does not look like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame state, bit timer, bit index and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      sh_q      <= '0;
      uart_busy <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh_q      <= sh_d;
      uart_busy <= (state_d != S_IDLE);
    end
  end

  // Next-state: half-bit wait to the start centre, then whole-bit strides
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d       = '0;
          sh_d[idx_q] = rx_s;
          idx_d       = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          if (rx_s) begin
            stop_ok = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output buffer: load a good byte one cycle after the stop sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      pend_q    <= stop_ok;
      frame_err <= stop_bad;
      overrun   <= pend_q && rx_valid && !rx_ready;
      if (pend_q && (!rx_valid || rx_ready)) begin
        rx_data  <= sh_q;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized scoreboard bench for uart_rx.
// Two instances: fast bit time (16) and board bit time (310).
module tb_uart_rx;

  localparam int CPB_A = 16;
  localparam int CPB_B = 310;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_a = 1'b1, rx_b = 1'b1;
  logic       ready_a = 1'b0, ready_b = 1'b1;
  logic [7:0] da, db;
  logic       va, vb, busy_a, busy_b, fe_a, fe_b, ov_a, ov_b;

  int ntest = 0;
  int nfail = 0;
  int cyc = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];

  int fe_cnt_a = 0, ov_cnt_a = 0, fe_cnt_b = 0, ov_cnt_b = 0;
  int both_cnt = 0, stab_viol = 0;
  int t_start = 0, t_rise = 0;
  logic busy5, busy_late;
  logic va_prev = 1'b0, hs_prev = 1'b0;
  logic [7:0] da_prev = '0;

  uart_rx #(.CLKS_PER_BIT(CPB_A), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a),
    .rx_data(da), .rx_valid(va), .rx_ready(ready_a),
    .uart_busy(busy_a), .frame_err(fe_a), .overrun(ov_a)
  );

  uart_rx #(.CLKS_PER_BIT(CPB_B), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b),
    .rx_data(db), .rx_valid(vb), .rx_ready(ready_b),
    .uart_busy(busy_b), .frame_err(fe_b), .overrun(ov_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop and compare at every handshake, tally flags
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) begin
      va_prev = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (va && ready_a) begin
        ntest++;
        if (qa.size() == 0) begin
          nfail++;
          $display("FAIL a_extra_byte got=%02h req=none", da);
        end else begin
          e = qa.pop_front();
          if (da !== e) begin
            nfail++;
            $display("FAIL a_byte got=%02h req=%02h", da, e);
          end
        end
      end
      if (vb && ready_b) begin
        ntest++;
        if (qb.size() == 0) begin
          nfail++;
          $display("FAIL b_extra_byte got=%02h req=none", db);
        end else begin
          e = qb.pop_front();
          if (db !== e) begin
            nfail++;
            $display("FAIL b_byte got=%02h req=%02h", db, e);
          end
        end
      end
      if (va_prev && va && !hs_prev && da !== da_prev) stab_viol++;
      if (va && !va_prev) t_rise = cyc;
      hs_prev = va && ready_a;
      va_prev = va;
      da_prev = da;
      if (fe_a) fe_cnt_a++;
      if (ov_a) ov_cnt_a++;
      if (fe_b) fe_cnt_b++;
      if (ov_b) ov_cnt_b++;
      if ((fe_a && ov_a) || (fe_b && ov_b)) both_cnt++;
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    ntest++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s got=%0d req=%0d", nm, act, req);
    end
  endtask

  task automatic drive(input int s, input logic v);
    if (s == 0) rx_a = v;
    else rx_b = v;
  endtask

  // Behavioural serializer: bit k occupies cycles [k*per, (k+1)*per)
  task automatic send(input int s, input logic [7:0] b,
                      input bit stop_hi, input real per);
    logic [9:0] fr;
    int n, k;
    fr = {stop_hi, b, 1'b0};
    n = int'($ceil(10.0 * per));
    for (int c = 0; c < n; c++) begin
      k = int'($floor(real'(c) / per));
      drive(s, fr[k]);
      if (s == 0 && c == 0) t_start = cyc;
      if (s == 0 && c == 6) busy5 = busy_a;
      if (s == 0 && c == n - 14) busy_late = busy_a;
      @(negedge clk);
    end
  endtask

  task automatic set_ready_a(input logic v);
    @(posedge clk);
    #1 ready_a = v;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 8000) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_drain"}, qa.size() + qb.size(), 0);
  endtask

  initial begin
    int fe0, ov0, lat, cnt;
    logic [7:0] r;

    // Reset state
    idle(4);
    chk("rst_valid", int'(va), 0);
    chk("rst_data", int'(da), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_flags", int'({fe_a, ov_a}), 0);
    rst_n = 1'b1;
    idle(4);
    set_ready_a(1'b1);

    // Single byte, latency and busy window
    fe0 = fe_cnt_a;
    ov0 = ov_cnt_a;
    qa.push_back(8'h55);
    send(0, 8'h55, 1'b1, real'(CPB_A));
    drain("single");
    lat = t_rise - t_start;
    chk("latency_in_window",
        int'(lat >= 9 * CPB_A + CPB_A / 2 + 2 && lat <= 9 * CPB_A + CPB_A / 2 + 4), 1);
    chk("busy_early", int'(busy5), 1);
    chk("busy_late", int'(busy_late), 1);
    idle(8);
    chk("busy_after", int'(busy_a), 0);
    chk("single_flags", (fe_cnt_a - fe0) + (ov_cnt_a - ov0), 0);

    // Back-to-back with no idle gap
    qa.push_back(8'hA5);
    qa.push_back(8'h00);
    qa.push_back(8'hFF);
    send(0, 8'hA5, 1'b1, real'(CPB_A));
    send(0, 8'h00, 1'b1, real'(CPB_A));
    send(0, 8'hFF, 1'b1, real'(CPB_A));
    drain("b2b");
    chk("b2b_flags", (fe_cnt_a - fe0) + (ov_cnt_a - ov0), 0);

    // Backpressure: second byte overruns and is lost
    set_ready_a(1'b0);
    qa.push_back(8'h3C);
    send(0, 8'h3C, 1'b1, real'(CPB_A));
    send(0, 8'hC3, 1'b1, real'(CPB_A));
    idle(20);
    chk("bp_valid", int'(va), 1);
    chk("bp_data", int'(da), 'h3C);
    chk("bp_overrun", ov_cnt_a - ov0, 1);
    set_ready_a(1'b1);
    set_ready_a(1'b0);
    chk("bp_valid_drop", int'(va), 0);
    set_ready_a(1'b1);
    idle(40);
    chk("bp_no_c3", int'(va), 0);
    chk("bp_queue", qa.size(), 0);

    // Framing error followed by a long break
    fe0 = fe_cnt_a;
    send(0, 8'h81, 1'b0, real'(CPB_A));
    cnt = 0;
    rx_a = 1'b0;
    repeat (40 * CPB_A) begin
      @(negedge clk);
      if (!busy_a) cnt++;
    end
    chk("break_busy_low_cycles", cnt, 0);
    chk("break_fe_pulses", fe_cnt_a - fe0, 1);
    chk("break_valid", int'(va), 0);
    rx_a = 1'b1;
    idle(3 * CPB_A);
    qa.push_back(8'h42);
    send(0, 8'h42, 1'b1, real'(CPB_A));
    drain("after_break");
    chk("after_break_fe", fe_cnt_a - fe0, 1);

    // Glitch: short low pulse never gets past START
    fe0 = fe_cnt_a;
    ov0 = ov_cnt_a;
    rx_a = 1'b0;
    idle(3);
    rx_a = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy_a) cnt++;
    end
    chk("glitch_short_busy", int'(cnt <= CPB_A / 2 + 1), 1);
    chk("glitch_valid", int'(va), 0);
    chk("glitch_flags", (fe_cnt_a - fe0) + (ov_cnt_a - ov0), 0);

    // Reset mid-frame discards buffered and partial bytes
    set_ready_a(1'b0);
    send(0, 8'h11, 1'b1, real'(CPB_A));
    idle(4);
    chk("rstmid_pre_valid", int'(va), 1);
    fork
      send(0, 8'h99, 1'b1, real'(CPB_A));
      begin
        repeat (5 * CPB_A + CPB_A / 2) @(negedge clk);
        chk("rstmid_pre_busy", int'(busy_a), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_valid", int'(va), 0);
        chk("rstmid_data", int'(da), 0);
        chk("rstmid_busy", int'(busy_a), 0);
      end
    join
    rst_n = 1'b1;
    idle(4);
    set_ready_a(1'b1);
    qa.push_back(8'h99);
    send(0, 8'h99, 1'b1, real'(CPB_A));
    drain("rstmid_fresh");

    // Full byte sweep at nominal rate
    for (int i = 0; i < 256; i++) begin
      qa.push_back(8'(i));
      send(0, 8'(i), 1'b1, real'(CPB_A));
    end
    drain("sweep");

    // Rate tolerance at the fast bit time
    for (int i = 0; i < 32; i++) begin
      r = 8'($urandom_range(255));
      qa.push_back(r);
      send(0, r, 1'b1, (i < 16) ? 0.98 * CPB_A : 1.02 * CPB_A);
    end
    drain("tol_a");

    // Board bit time: nominal, 2% fast, 2% slow
    for (int i = 0; i < 7; i++) begin
      r = 8'($urandom_range(255));
      qb.push_back(r);
      send(1, r, 1'b1,
           (i < 3) ? real'(CPB_B) : ((i < 5) ? 0.98 * CPB_B : 1.02 * CPB_B));
    end
    drain("tol_b");

    chk("total_fe_a", fe_cnt_a, 1);
    chk("total_ov_a", ov_cnt_a, 1);
    chk("flags_b", fe_cnt_b + ov_cnt_b, 0);
    chk("fe_ov_together", both_cnt, 0);
    chk("data_stable_while_valid", stab_viol, 0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
